pong_ball_ctrl: RTL and testbench

- Ball motion, bounce and scoring engine for the two-player Pong game, directly downstream of the paddle blocks.
- Consumes both paddle Y positions, moves the ball across the tile grid at a fixed step rate, reflects it off the walls and paddles, and flags a score on a miss.
- Produces the registered ball draw strobe for the tile-level pixel mux, plus score pulses for the score counter.

---
 rtl/pong_ball_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_pong_ball_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/pong_ball_ctrl.sv
// pong_ball_ctrl
//   Ball motion, bounce and scoring engine for two-player Pong. The ball moves
//   one tile in X and one tile in Y on every step, where a step is one
//   c_BALL_SPEED+1 clock period. The ball reflects off the top and bottom
//   walls and off the paddles. If the ball misses a paddle, the opposite
//   player scores. The ball then re-centres and the engine waits for a serve.
//
// Ports
//   i_Clk            system clock
//   i_Reset          synchronous active-high reset
//   i_Game_Start     single-cycle serve request (honoured only in IDLE)
//   i_Col_Count      current tile column from the tile scanner
//   i_Row_Count      current tile row from the tile scanner
//   i_Paddle_Y_P1    left paddle top row
//   i_Paddle_Y_P2    right paddle top row
//   o_Draw_Ball      registered: the ball occupies the scanned tile
//   o_Ball_X         ball column
//   o_Ball_Y         ball row
//   o_P1_Score_Pulse one-cycle pulse, left player scored
//   o_P2_Score_Pulse one-cycle pulse, right player scored
//   o_Active         high while the ball is in play
module pong_ball_ctrl #(
    parameter int c_GAME_WIDTH    = 40,
    parameter int c_GAME_HEIGHT   = 30,
    parameter int c_PADDLE_HEIGHT = 5,
    parameter int c_PADDLE_COL_P1 = 0,
    parameter int c_PADDLE_COL_P2 = 39,
    parameter int c_BALL_SPEED    = 1250000
) (
    input  logic       i_Clk,
    input  logic       i_Reset,
    input  logic       i_Game_Start,
    input  logic [5:0] i_Col_Count,
    input  logic [5:0] i_Row_Count,
    input  logic [5:0] i_Paddle_Y_P1,
    input  logic [5:0] i_Paddle_Y_P2,
    output logic       o_Draw_Ball,
    output logic [5:0] o_Ball_X,
    output logic [5:0] o_Ball_Y,
    output logic       o_P1_Score_Pulse,
    output logic       o_P2_Score_Pulse,
    output logic       o_Active
);

    localparam logic [5:0]  CENTER_X      = 6'(c_GAME_WIDTH / 2);
    localparam logic [5:0]  CENTER_Y      = 6'(c_GAME_HEIGHT / 2);
    localparam logic [5:0]  BOTTOM_ROW    = 6'(c_GAME_HEIGHT - 1);
    localparam logic [5:0]  COL_BEFORE_P2 = 6'(c_PADDLE_COL_P2 - 1);
    localparam logic [5:0]  COL_AFTER_P1  = 6'(c_PADDLE_COL_P1 + 1);
    localparam logic [6:0]  PADDLE_SPAN   = 7'(c_PADDLE_HEIGHT);
    localparam logic [31:0] STEP_LAST     = 32'(c_BALL_SPEED);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUNNING = 2'd1,
        SCORED  = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] count, count_nxt;
    logic [5:0]  ball_x, ball_x_nxt;
    logic [5:0]  ball_y, ball_y_nxt;
    logic        dir_right, dir_right_nxt;   // 1 = moving right
    logic        dir_down, dir_down_nxt;     // 1 = moving down
    logic        p1_pulse_nxt, p2_pulse_nxt;
    logic        hit_p1, hit_p2;
    logic        step_now;

    // The paddle bound is formed at 7 bits, so a paddle near row 63 cannot
    // wrap around and appear to cover the top rows.
    assign hit_p1 = ({1'b0, ball_y} >= {1'b0, i_Paddle_Y_P1}) &&
                    ({1'b0, ball_y} <= ({1'b0, i_Paddle_Y_P1} + PADDLE_SPAN));
    assign hit_p2 = ({1'b0, ball_y} >= {1'b0, i_Paddle_Y_P2}) &&
                    ({1'b0, ball_y} <= ({1'b0, i_Paddle_Y_P2} + PADDLE_SPAN));

    assign step_now = (count == STEP_LAST);

    always_comb begin
        state_nxt     = state;
        count_nxt     = count;
        ball_x_nxt    = ball_x;
        ball_y_nxt    = ball_y;
        dir_right_nxt = dir_right;
        dir_down_nxt  = dir_down;
        p1_pulse_nxt  = 1'b0;
        p2_pulse_nxt  = 1'b0;

        case (state)
            IDLE: begin
                count_nxt  = '0;
                ball_x_nxt = CENTER_X;
                ball_y_nxt = CENTER_Y;
                if (i_Game_Start) begin
                    state_nxt = RUNNING;
                end
            end

            RUNNING: begin
                if (!step_now) begin
                    count_nxt = count + 32'd1;
                end else begin
                    count_nxt = '0;

                    // X axis: the paddle test happens one column before the
                    // paddle, using the pre-step row.
                    if (dir_right && ball_x == COL_BEFORE_P2) begin
                        if (hit_p2) begin
                            dir_right_nxt = 1'b0;
                            ball_x_nxt    = ball_x - 6'd1;
                        end else begin
                            p1_pulse_nxt = 1'b1;
                        end
                    end else if (!dir_right && ball_x == COL_AFTER_P1) begin
                        if (hit_p1) begin
                            dir_right_nxt = 1'b1;
                            ball_x_nxt    = ball_x + 6'd1;
                        end else begin
                            p2_pulse_nxt = 1'b1;
                        end
                    end else if (dir_right) begin
                        ball_x_nxt = ball_x + 6'd1;
                    end else begin
                        ball_x_nxt = ball_x - 6'd1;
                    end

                    // Y axis: reflect off the bottom and top walls.
                    if (dir_down && ball_y == BOTTOM_ROW) begin
                        dir_down_nxt = 1'b0;
                        ball_y_nxt   = ball_y - 6'd1;
                    end else if (!dir_down && ball_y == 6'd0) begin
                        dir_down_nxt = 1'b1;
                        ball_y_nxt   = ball_y + 6'd1;
                    end else if (dir_down) begin
                        ball_y_nxt = ball_y + 6'd1;
                    end else begin
                        ball_y_nxt = ball_y - 6'd1;
                    end

                    // A miss overrides the motion. The next serve heads
                    // toward the player who conceded, and dir_y is kept.
                    if (p1_pulse_nxt || p2_pulse_nxt) begin
                        ball_x_nxt    = CENTER_X;
                        ball_y_nxt    = CENTER_Y;
                        dir_right_nxt = p1_pulse_nxt;
                        dir_down_nxt  = dir_down;
                        state_nxt     = SCORED;
                    end
                end
            end

            SCORED: begin
                if (!step_now) begin
                    count_nxt = count + 32'd1;
                end else begin
                    count_nxt = '0;
                    state_nxt = IDLE;
                end
            end

            default: begin
                state_nxt = IDLE;
                count_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state            <= IDLE;
            count            <= '0;
            ball_x           <= CENTER_X;
            ball_y           <= CENTER_Y;
            dir_right        <= 1'b1;
            dir_down         <= 1'b1;
            o_Draw_Ball      <= 1'b0;
            o_P1_Score_Pulse <= 1'b0;
            o_P2_Score_Pulse <= 1'b0;
            o_Active         <= 1'b0;
        end else begin
            state            <= state_nxt;
            count            <= count_nxt;
            ball_x           <= ball_x_nxt;
            ball_y           <= ball_y_nxt;
            dir_right        <= dir_right_nxt;
            dir_down         <= dir_down_nxt;
            o_P1_Score_Pulse <= p1_pulse_nxt;
            o_P2_Score_Pulse <= p2_pulse_nxt;
            o_Active         <= (state_nxt == RUNNING);
            // Draw strobe compares against the ball position before this edge.
            o_Draw_Ball      <= (i_Col_Count == ball_x) && (i_Row_Count == ball_y);
        end
    end

    assign o_Ball_X = ball_x;
    assign o_Ball_Y = ball_y;

endmodule

// File: tb/tb_pong_ball_ctrl.sv
module tb_pong_ball_ctrl;

    localparam int SPEED  = 2;
    localparam int WIDTH  = 40;
    localparam int HEIGHT = 30;
    localparam int PH     = 5;
    localparam int COL_P1 = 0;
    localparam int COL_P2 = 39;

    logic       clk;
    logic       i_Reset;
    logic       i_Game_Start;
    logic [5:0] i_Col_Count;
    logic [5:0] i_Row_Count;
    logic [5:0] i_Paddle_Y_P1;
    logic [5:0] i_Paddle_Y_P2;
    logic       o_Draw_Ball;
    logic [5:0] o_Ball_X;
    logic [5:0] o_Ball_Y;
    logic       o_P1_Score_Pulse;
    logic       o_P2_Score_Pulse;
    logic       o_Active;

    pong_ball_ctrl #(
        .c_GAME_WIDTH   (WIDTH),
        .c_GAME_HEIGHT  (HEIGHT),
        .c_PADDLE_HEIGHT(PH),
        .c_PADDLE_COL_P1(COL_P1),
        .c_PADDLE_COL_P2(COL_P2),
        .c_BALL_SPEED   (SPEED)
    ) dut (
        .i_Clk           (clk),
        .i_Reset         (i_Reset),
        .i_Game_Start    (i_Game_Start),
        .i_Col_Count     (i_Col_Count),
        .i_Row_Count     (i_Row_Count),
        .i_Paddle_Y_P1   (i_Paddle_Y_P1),
        .i_Paddle_Y_P2   (i_Paddle_Y_P2),
        .o_Draw_Ball     (o_Draw_Ball),
        .o_Ball_X        (o_Ball_X),
        .o_Ball_Y        (o_Ball_Y),
        .o_P1_Score_Pulse(o_P1_Score_Pulse),
        .o_P2_Score_Pulse(o_P2_Score_Pulse),
        .o_Active        (o_Active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int   cyc;
        logic [5:0] x;
        logic [5:0] y;
        logic act;
        logic p1;
        logic p2;
        logic draw;
    } exp_t;

    exp_t exp_q[$];

    int n_checks = 0;
    int n_pass   = 0;
    int cycle_no = 0;

    // Reference model: mode 0 = waiting for serve, 1 = in play, 2 = point over.
    // Position and velocity are plain integers; a step is taken once a full
    // period of SPEED+1 clocks has elapsed.
    int m_mode, m_x, m_y, m_vx, m_vy, m_elapsed;
    bit m_act, m_p1, m_p2, m_draw;

    function automatic bit covers(int paddle_top, int row);
        return (row >= paddle_top) && (row <= paddle_top + PH);
    endfunction

    task automatic model_reset();
        m_mode = 0; m_x = WIDTH / 2; m_y = HEIGHT / 2;
        m_vx = 1; m_vy = 1; m_elapsed = 0;
        m_act = 0; m_p1 = 0; m_p2 = 0; m_draw = 0;
    endtask

    task automatic model_step(input int py1, input int py2);
        int nx, ny;
        bit missed;
        missed = 0;
        nx = m_x + m_vx;
        if (nx == COL_P2) begin
            if (covers(py2, m_y)) begin m_vx = -1; nx = m_x - 1; end
            else begin m_p1 = 1; missed = 1; end
        end else if (nx == COL_P1) begin
            if (covers(py1, m_y)) begin m_vx = 1; nx = m_x + 1; end
            else begin m_p2 = 1; missed = 1; end
        end
        if (missed) begin
            m_x = WIDTH / 2; m_y = HEIGHT / 2;
            m_vx = m_p1 ? 1 : -1;
            m_mode = 2;
            return;
        end
        ny = m_y + m_vy;
        if (ny < 0 || ny > HEIGHT - 1) begin
            m_vy = -m_vy;
            ny = m_y + m_vy;
        end
        m_x = nx; m_y = ny;
    endtask

    task automatic model_clock(input bit rst, input bit start, input int col, input int row,
                               input int py1, input int py2);
        if (rst) begin
            model_reset();
            return;
        end
        m_draw = (col == m_x) && (row == m_y);
        m_p1 = 0; m_p2 = 0;
        case (m_mode)
            0: if (start) begin m_mode = 1; m_elapsed = 0; end
            1: begin
                m_elapsed++;
                if (m_elapsed == SPEED + 1) begin
                    m_elapsed = 0;
                    model_step(py1, py2);
                end
            end
            default: begin
                m_elapsed++;
                if (m_elapsed == SPEED + 1) begin
                    m_elapsed = 0;
                    m_mode = 0;
                end
            end
        endcase
        m_act = (m_mode == 1);
    endtask

    // Drive one clock of stimulus on the falling edge and queue the response
    // expected after the following rising edge.
    task automatic drive(input bit rst, input bit start);
        exp_t e;
        int col, row;
        @(negedge clk);
        cycle_no++;
        if ($urandom_range(0, 3) == 0) begin
            col = $urandom_range(0, 63);
            row = $urandom_range(0, 63);
        end else begin
            col = m_x + $urandom_range(0, 2) - 1;
            row = m_y + $urandom_range(0, 2) - 1;
            if (col < 0) col = 0;
            if (row < 0) row = 0;
        end
        i_Reset      = rst;
        i_Game_Start = start;
        i_Col_Count  = 6'(col);
        i_Row_Count  = 6'(row);
        model_clock(rst, start, col, row, int'(i_Paddle_Y_P1), int'(i_Paddle_Y_P2));
        e.cyc  = cycle_no;
        e.x    = 6'(m_x);
        e.y    = 6'(m_y);
        e.act  = m_act;
        e.p1   = m_p1;
        e.p2   = m_p2;
        e.draw = m_draw;
        exp_q.push_back(e);
    endtask

    task automatic check(input string name, input int cyc, input logic [5:0] act, input logic [5:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, req);
    endtask

    // Monitor: pops one expected response per rising edge, sampled 1 time unit later.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("ball_x",   e.cyc, o_Ball_X, e.x);
                check("ball_y",   e.cyc, o_Ball_Y, e.y);
                check("active",   e.cyc, {5'd0, o_Active}, {5'd0, e.act});
                check("p1_score", e.cyc, {5'd0, o_P1_Score_Pulse}, {5'd0, e.p1});
                check("p2_score", e.cyc, {5'd0, o_P2_Score_Pulse}, {5'd0, e.p2});
                check("draw",     e.cyc, {5'd0, o_Draw_Ball}, {5'd0, e.draw});
            end
        end
    end

    initial begin
        i_Reset       = 1'b1;
        i_Game_Start  = 1'b0;
        i_Col_Count   = 6'd0;
        i_Row_Count   = 6'd0;
        i_Paddle_Y_P1 = 6'd12;
        i_Paddle_Y_P2 = 6'd22;
        model_reset();

        // Reset, then a long idle stretch with no serve.
        repeat (3) drive(1'b1, 1'b0);
        repeat (100) drive(1'b0, 1'b0);

        // Serve with the right paddle at row 22: wall bounce then paddle hit.
        drive(1'b0, 1'b1);
        repeat (75) drive(1'b0, 1'b0);

        // Reset, then the right paddle misses; serves during play and while
        // scored must be ignored.
        drive(1'b1, 1'b0);
        i_Paddle_Y_P2 = 6'd0;
        drive(1'b0, 1'b1);
        for (int i = 0; i < 64; i++) drive(1'b0, (i % 7) == 3);
        repeat (4) drive(1'b0, 1'b0);
        drive(1'b0, 1'b1);
        repeat (12) drive(1'b0, 1'b0);

        // Reset in the middle of a step period.
        drive(1'b0, 1'b0);
        drive(1'b1, 1'b0);
        repeat (5) drive(1'b0, 1'b0);

        // Randomized play: paddles move, occasional serves and resets.
        for (int i = 0; i < 3000; i++) begin
            if (i % 40 == 0) begin
                i_Paddle_Y_P1 = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(58, 63))
                                                             : 6'($urandom_range(0, 29));
                i_Paddle_Y_P2 = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(58, 63))
                                                             : 6'($urandom_range(0, 29));
            end
            drive($urandom_range(0, 299) == 0, $urandom_range(0, 19) == 0);
        end

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
